// File: rtl/rib_mem_slave.sv
// ---------------------------------------------------------------------------
// rib_mem_slave
// Word-wide RAM responder on the RIB data bus. It captures a request,
// inserts WAIT_CYCLES wait states, then acknowledges for one cycle. A decode
// miss gives an error-flagged ack, so the initiator never hangs.
//
// Parameters
//   BASE_ADDR   byte address of word 0
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES wait states between request capture and ack (0..15)
//
// Ports
//   clk     clock
//   rst     synchronous reset, active-high
//   req_i   access request, held by the initiator until ack
//   we_i    1 = write, 0 = read; valid with req_i
//   addr_i  byte address; bits [1:0] ignored
//   data_i  write data; valid with req_i
//   data_o  read data; valid while ack_o = 1, holds last read value otherwise
//   ack_o   one-cycle response strobe
//   err_o   decode-miss flag; valid while ack_o = 1
//   busy_o  transaction in progress
// ---------------------------------------------------------------------------
module rib_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic        NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Request fields captured in IDLE
    logic               cap_we;
    logic               cap_hit;
    logic [IDX_W-1:0]   cap_idx;
    logic [31:0]        cap_data;

    logic [31:0]        mem [DEPTH];

    // Address decode on the live request
    logic [31:0]        offset_c;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;

    assign offset_c = addr_i - BASE_ADDR;
    assign hit_c    = (offset_c < SPAN);
    assign idx_c    = offset_c[IDX_W+1:2];

    // With zero wait states RESP is entered on the capture edge itself, so the
    // live fields must be used instead of the (not yet loaded) captured ones.
    logic               use_live_c;
    logic               sel_we_c;
    logic               sel_hit_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic [31:0]        sel_data_c;
    logic               go_resp_c;
    logic [31:0]        rd_word_c;

    assign use_live_c = (state == ST_IDLE);
    assign sel_we_c   = use_live_c ? we_i   : cap_we;
    assign sel_hit_c  = use_live_c ? hit_c  : cap_hit;
    assign sel_idx_c  = use_live_c ? idx_c  : cap_idx;
    assign sel_data_c = use_live_c ? data_i : cap_data;

    // Edge that moves the FSM into RESP
    assign go_resp_c = req_i &&
                       (((state == ST_IDLE) && NO_WAIT) ||
                        ((state == ST_WAIT) && (cnt == CNT_W'(1))));

    assign rd_word_c = mem[sel_idx_c];

    // Storage array; not reset, and a reset edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && go_resp_c && sel_we_c && sel_hit_c) begin
            mem[sel_idx_c] <= sel_data_c;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            data_o   <= '0;
            busy_o   <= 1'b0;
            cap_we   <= 1'b0;
            cap_hit  <= 1'b0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        cap_we   <= we_i;
                        cap_hit  <= hit_c;
                        cap_idx  <= idx_c;
                        cap_data <= data_i;
                        cnt      <= WAIT_LD;
                        busy_o   <= 1'b1;
                        state    <= NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req_i) begin
                        // Initiator withdrew: drop the access silently
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase

            // Response payload launched together with the RESP state
            if (go_resp_c) begin
                ack_o <= 1'b1;
                if (!sel_hit_c) begin
                    err_o  <= 1'b1;
                    data_o <= '0;
                end else if (!sel_we_c) begin
                    data_o <= rd_word_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_rib_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_rib_mem_slave
// Three slaves with 2, 0 and 5 wait states share we/addr/data and reset, each
// with its own req. Directed scenarios followed by random transactions,
// checked against an array model of memory and last read value.
// ---------------------------------------------------------------------------
module tb_rib_mem_slave;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          NS    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        req  [NS];
    logic [31:0] dout [NS];
    logic        ack  [NS];
    logic        err  [NS];
    logic        busy [NS];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ack_cyc = 0;

    // Reference model
    logic [31:0] m_mem   [NS][DEPTH];
    bit          m_known [NS][DEPTH];
    logic [31:0] m_last  [NS];
    bit          m_last_known [NS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rib_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0]),
        .busy_o(busy[0]));

    rib_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1]),
        .busy_o(busy[1]));

    rib_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(5)) u_dut_w5 (
        .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(dout[2]), .ack_o(ack[2]), .err_o(err[2]),
        .busy_o(busy[2]));

    function automatic int wait_of(input int s);
        case (s)
            0:       return 2;
            1:       return 0;
            default: return 5;
        endcase
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < DEPTH * 4;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset;
        for (int s = 0; s < NS; s++) begin
            m_last[s]       = '0;
            m_last_known[s] = 1'b1;
        end
    endtask

    // One transaction on slave s. abort_k > 0 drops req before the k-th edge
    // after capture. hold keeps req high after ack (caller then passes in_resp).
    task automatic run_txn(input int s, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int abort_k,
                           input bit hold, input bit in_resp,
                           output bit resp_pending);
        int  n;
        int  ix;
        bit  h;
        resp_pending = 1'b0;
        we = w; addr = a; wdata = d; req[s] = 1'b1;
        if (in_resp) begin
            tick();
            chk("b2b_gap_ack", 32'(ack[s]), 32'd0);
            chk("b2b_gap_busy", 32'(busy[s]), 32'd0);
        end
        tick();
        chk("cap_busy", 32'(busy[s]), 32'd1);
        // Fields must be ignored after capture
        we = 1'($urandom); addr = $urandom; wdata = $urandom;
        h  = m_hit(a);
        ix = m_idx(a);
        if (abort_k > 0) begin
            repeat (abort_k - 1) begin
                chk("abort_noack_pre", 32'(ack[s]), 32'd0);
                tick();
            end
            req[s] = 1'b0;
            tick();
            chk("abort_ack", 32'(ack[s]), 32'd0);
            chk("abort_busy", 32'(busy[s]), 32'd0);
            chk("abort_err", 32'(err[s]), 32'd0);
            return;
        end
        n = 1;
        while (!ack[s] && n < 40) begin
            tick();
            n++;
        end
        if (!ack[s]) begin
            chk("ack_timeout", 32'd0, 32'd1);
            req[s] = 1'b0;
            tick();
            return;
        end
        last_ack_cyc = cyc;
        chk("latency", 32'(n), 32'(wait_of(s) + 1));
        if (!h) begin
            chk("miss_err", 32'(err[s]), 32'd1);
            chk("miss_data", dout[s], 32'd0);
            m_last[s] = '0;
            m_last_known[s] = 1'b1;
        end else begin
            chk("hit_err", 32'(err[s]), 32'd0);
            if (w) begin
                if (m_last_known[s]) chk("wr_data_hold", dout[s], m_last[s]);
                m_mem[s][ix]   = d;
                m_known[s][ix] = 1'b1;
            end else begin
                if (m_known[s][ix]) chk("rd_data", dout[s], m_mem[s][ix]);
                m_last[s]       = m_mem[s][ix];
                m_last_known[s] = m_known[s][ix];
            end
        end
        if (hold) begin
            resp_pending = 1'b1;
            return;
        end
        req[s] = 1'b0;
        tick();
        chk("post_ack", 32'(ack[s]), 32'd0);
        chk("post_err", 32'(err[s]), 32'd0);
        chk("post_busy", 32'(busy[s]), 32'd0);
        if (m_last_known[s]) chk("post_data_hold", dout[s], m_last[s]);
    endtask

    task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit rp;
        run_txn(s, w, a, d, 0, 1'b0, 1'b0, rp);
    endtask

    logic [31:0] bnd [5];

    initial begin
        bit rp;
        bit prev_hold;
        int prev_s;
        int a1;
        for (int s = 0; s < NS; s++) begin
            req[s] = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) m_known[s][i] = 1'b0;
        end
        m_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int s = 0; s < NS; s++) begin
            chk("rst_ack", 32'(ack[s]), 32'd0);
            chk("rst_err", 32'(err[s]), 32'd0);
            chk("rst_data", dout[s], 32'd0);
            chk("rst_busy", 32'(busy[s]), 32'd0);
        end

        // Basic read latency with two wait states
        txn(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        txn(0, 1'b0, 32'h1000_0010, 32'h0);
        chk("basic_rd_val", m_last[0], 32'hDEAD_BEEF);

        // Zero wait states
        txn(1, 1'b1, 32'h1000_0000, 32'h1234_5678);
        txn(1, 1'b0, 32'h1000_0000, 32'h0);

        // Decode misses
        txn(0, 1'b1, 32'h1000_0000, 32'h5555_AAAA);
        txn(0, 1'b0, 32'h2000_0000, 32'h0);
        txn(0, 1'b1, 32'h1000_1000, 32'h0BAD_0BAD);
        txn(0, 1'b0, 32'h1000_0000, 32'h0);

        // Abort mid-wait
        txn(0, 1'b1, 32'h1000_0004, 32'h1111_0004);
        run_txn(0, 1'b1, 32'h1000_0004, 32'hCAFE_F00D, 1, 1'b0, 1'b0, rp);
        txn(0, 1'b0, 32'h1000_0004, 32'h0);

        // Reset during the wait of a write
        txn(0, 1'b1, 32'h1000_0014, 32'h0000_A5A5);
        we = 1'b1; addr = 32'h1000_0014; wdata = 32'hFFFF_FFFF; req[0] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ack", 32'(ack[0]), 32'd0);
        chk("midrst_data", dout[0], 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_err", 32'(err[0]), 32'd0);
        rst = 1'b0; req[0] = 1'b0;
        m_reset();
        tick();
        txn(0, 1'b0, 32'h1000_0014, 32'h0);

        // Back-to-back reads with req held high
        for (int s = 0; s < NS; s++) begin
            txn(s, 1'b1, 32'h1000_0008, 32'h1);
            txn(s, 1'b1, 32'h1000_000C, 32'h2);
            run_txn(s, 1'b0, 32'h1000_0008, 32'h0, 0, 1'b1, 1'b0, rp);
            a1 = last_ack_cyc;
            run_txn(s, 1'b0, 32'h1000_000C, 32'h0, 0, 1'b0, rp, rp);
            chk("b2b_ack_gap", 32'(last_ack_cyc - a1), 32'(wait_of(s) + 2));
            chk("b2b_second_val", m_last[s], 32'h2);
        end

        // Random traffic
        bnd[0] = BASE - 32'd4;
        bnd[1] = BASE + 32'(DEPTH * 4) - 32'd4;
        bnd[2] = BASE + 32'(DEPTH * 4);
        bnd[3] = BASE - 32'd1;
        bnd[4] = BASE + 32'(DEPTH * 4) - 32'd1;
        prev_hold = 1'b0;
        prev_s    = 0;
        for (int t = 0; t < 300; t++) begin
            int          s;
            int          mode;
            int          ak;
            bit          w;
            bit          hold;
            logic [31:0] a;
            s    = prev_hold ? prev_s : int'($urandom_range(0, NS - 1));
            w    = 1'($urandom);
            mode = int'($urandom_range(0, 5));
            if (mode <= 2)      a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            else if (mode == 3) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (mode == 4) a = bnd[$urandom_range(0, 4)];
            else                a = $urandom;
            ak = 0;
            if (wait_of(s) > 0 && $urandom_range(0, 5) == 0)
                ak = int'($urandom_range(1, wait_of(s)));
            hold = (ak == 0) && ($urandom_range(0, 3) == 0);
            run_txn(s, w, a, $urandom, ak, hold, prev_hold, rp);
            prev_hold = rp;
            prev_s    = s;
            if (!rp) repeat ($urandom_range(0, 2)) tick();
        end
        if (prev_hold) begin
            req[prev_s] = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
